bresenham_line_drawer: RTL and testbench

BRESENHAM_LINE_DRAWER -- requirements
Module: bresenham_line_drawer

---
 rtl/bresenham_line_drawer.sv | 137 +++++++++++++
 tb/tb_bresenham_line_drawer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_line_drawer.sv
// rtl/bresenham_line_drawer.sv - integer Bresenham line rasteriser with a pixel_write/pixel_ready handshake.
// Optional off-screen pixel skipping is enabled by defining BRESENHAM_LINE_DRAWER_CLIP_EN.
module bresenham_line_drawer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_write,
    input  logic               pixel_ready
);

    // Two guard bits keep 2*err representable for any pair of endpoints.
    localparam int E_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    localparam logic [X_WIDTH-1:0] X_ONE = 1;
    localparam logic [Y_WIDTH-1:0] Y_ONE = 1;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t               state;
    logic [X_WIDTH-1:0]   x_end;
    logic [Y_WIDTH-1:0]   y_end;
    logic signed [E_WIDTH-1:0] dx;
    logic signed [E_WIDTH-1:0] dy;
    logic signed [E_WIDTH-1:0] err;
    logic                 sx_neg;
    logic                 sy_neg;

    logic signed [E_WIDTH-1:0] x1_e, x2_e, y1_e, y2_e;
    logic signed [E_WIDTH-1:0] diff_x, diff_y;
    logic signed [E_WIDTH-1:0] dx_init, dy_init;
    logic signed [E_WIDTH-1:0] e2, err_next;
    logic                 step_x, step_y;
    logic [X_WIDTH-1:0]   x_next;
    logic [Y_WIDTH-1:0]   y_next;
    logic                 last_pixel;
    logic                 advance;
    logic                 first_visible;
    logic                 next_visible;

    assign x1_e = $signed({{(E_WIDTH-X_WIDTH){1'b0}}, x1});
    assign x2_e = $signed({{(E_WIDTH-X_WIDTH){1'b0}}, x2});
    assign y1_e = $signed({{(E_WIDTH-Y_WIDTH){1'b0}}, y1});
    assign y2_e = $signed({{(E_WIDTH-Y_WIDTH){1'b0}}, y2});
    assign diff_x = x2_e - x1_e;
    assign diff_y = y2_e - y1_e;
    assign dx_init = (diff_x < 0) ? -diff_x : diff_x;
    assign dy_init = (diff_y < 0) ? diff_y : -diff_y;

    // Both step decisions use the same e2 derived from the pre-update error.
    assign e2       = {err[E_WIDTH-2:0], 1'b0};
    assign step_x   = (e2 >= dy);
    assign step_y   = (e2 <= dx);
    assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    assign x_next   = step_x ? (sx_neg ? pixel_x - X_ONE : pixel_x + X_ONE) : pixel_x;
    assign y_next   = step_y ? (sy_neg ? pixel_y - Y_ONE : pixel_y + Y_ONE) : pixel_y;
    assign last_pixel = (pixel_x == x_end) && (pixel_y == y_end);

`ifdef BRESENHAM_LINE_DRAWER_CLIP_EN
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS);

    assign first_visible = ({1'b0, x1} < X_LIMIT) && ({1'b0, y1} < Y_LIMIT);
    assign next_visible  = ({1'b0, x_next} < X_LIMIT) && ({1'b0, y_next} < Y_LIMIT);
    // Off-screen pixels are never offered, so they step without a handshake.
    assign advance = (state == DRAW) && (pixel_ready || !pixel_write);
`else
    assign first_visible = 1'b1;
    assign next_visible  = 1'b1;
    assign advance = (state == DRAW) && pixel_ready;
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_write <= 1'b0;
            x_end       <= '0;
            y_end       <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pixel_write <= 1'b0;
                    if (start) begin
                        state       <= DRAW;
                        pixel_x     <= x1;
                        pixel_y     <= y1;
                        pixel_write <= first_visible;
                        x_end       <= x2;
                        y_end       <= y2;
                        dx          <= dx_init;
                        dy          <= dy_init;
                        err         <= dx_init + dy_init;
                        sx_neg      <= (diff_x < 0);
                        sy_neg      <= (diff_y < 0);
                    end
                end
                DRAW: begin
                    if (advance) begin
                        if (last_pixel) begin
                            state       <= IDLE;
                            pixel_write <= 1'b0;
                        end else begin
                            pixel_x     <= x_next;
                            pixel_y     <= y_next;
                            err         <= err_next;
                            pixel_write <= next_visible;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    pixel_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// tb/tb_bresenham_line_drawer.sv - self-checking bench for bresenham_line_drawer.
module tb_bresenham_line_drawer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
`ifdef BRESENHAM_LINE_DRAWER_CLIP_EN
    localparam int CLIP_CNT = 2;
`else
    localparam int CLIP_CNT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x1 = '0, x2 = '0, pixel_x;
    logic [YW-1:0] y1 = '0, y2 = '0, pixel_y;
    logic          pixel_write;
    logic          pixel_ready = 1'b0;

    always #5 clk = ~clk;

    bresenham_line_drawer #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .x1(x1), .x2(x2), .y1(y1), .y2(y2),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_write(pixel_write), .pixel_ready(pixel_ready)
    );

    typedef struct {
        int x1, y1, x2, y2;
        int cnt;
        int mode;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit last_step;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    function automatic bit visible(input int x, input int y);
`ifdef BRESENHAM_LINE_DRAWER_CLIP_EN
        return (x < H) && (y < V);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: textbook integer Bresenham over plain ints, producing the written pixel list.
    task automatic model(input int ax1, input int ay1, input int ax2, input int ay2);
        int x, y, dx, dy, sx, sy, err, e2, guard;
        exp_q.delete();
        x = ax1; y = ay1;
        dx = iabs(ax2 - ax1);
        dy = -iabs(ay2 - ay1);
        sx = (ax2 < ax1) ? -1 : 1;
        sy = (ay2 < ay1) ? -1 : 1;
        err = dx + dy;
        guard = 0;
        forever begin
            if (visible(x, y)) exp_q.push_back(pk(x, y));
            if ((x == ax2 && y == ay2) || guard > 2000) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            guard++;
        end
    endtask

    // mode 0: always ready, 1: random backpressure, 2: 3-cycle stall after 2nd pixel,
    // 3: stray start pulse mid-line.  max_xfers>0 abandons the line after that many writes.
    task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                            input int mode, input int max_xfers);
        int n, xfers, stall_left;
        bit pr, stalled;
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        n = 0;
        while (!ready && n < 5000) begin @(negedge clk); n++; end
        if (!ready) begin check("wait_ready", ready, 1); return; end
        model(ax1, ay1, ax2, ay2);
        x1 = XW'(ax1); y1 = YW'(ay1); x2 = XW'(ax2); y2 = YW'(ay2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = XW'($urandom_range(0, 2**XW-1)); x2 = XW'($urandom_range(0, 2**XW-1));
        y1 = YW'($urandom_range(0, 2**YW-1)); y2 = YW'($urandom_range(0, 2**YW-1));
        check("ready_low", ready, 0);
        check("first_pixel", pk(pixel_x, pixel_y), pk(ax1, ay1));
        got_q.delete();
        xfers = 0; stall_left = 3; stalled = 0; last_step = 0; n = 0;
        hx = '0; hy = '0;
        while (!ready && n < 5000) begin
            if (stalled) begin
                check("stall_write", pixel_write, 1);
                check("stall_coord", pk(pixel_x, pixel_y), pk(hx, hy));
            end
            pr = 1'b1;
            start = 1'b0;
            case (mode)
                1: pr = 1'($urandom_range(0, 1));
                2: if (xfers == 2 && stall_left > 0) begin pr = 1'b0; stall_left--; end
                3: if (xfers == 5) begin start = 1'b1; x1 = '0; y1 = '0; x2 = '0; y2 = '0; end
                default: pr = 1'b1;
            endcase
            pixel_ready = pr;
            stalled = pixel_write && !pr;
            hx = pixel_x; hy = pixel_y;
`ifdef BRESENHAM_LINE_DRAWER_CLIP_EN
            last_step = pr || !pixel_write;
`else
            last_step = pixel_write && pr;
`endif
            if (pixel_write && pr) begin
                got_q.push_back(pk(pixel_x, pixel_y));
                xfers++;
            end
            @(negedge clk);
            n++;
            if (max_xfers > 0 && xfers >= max_xfers) return;
        end
        start = 1'b0;
        pixel_ready = 1'b0;
        check("line_done", ready, 1);
        check("ready_rise", last_step, 1);
        check("idle_write", pixel_write, 0);
        check("pixel_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("pixel%0d", i), got_q[i], exp_q[i]);
    endtask

    initial begin
        vec_t tab[8];
        int g27x[6];
        int g27y[6];
        int ax1, ay1, ax2, ay2, writes;

        tab[0] = '{0, 240, 7, 240, 8, 0};
        tab[1] = '{0, 0, 2, 5, 6, 0};
        tab[2] = '{10, 10, 5, 15, 6, 2};
        tab[3] = '{100, 100, 100, 100, 1, 0};
        tab[4] = '{0, 0, 20, 0, 21, 3};
        tab[5] = '{0, 478, 0, 481, CLIP_CNT, 0};
        tab[6] = '{639, 0, 0, 479, 640, 1};
        tab[7] = '{5, 5, 5, 0, 6, 1};
        g27x = '{0, 0, 1, 1, 2, 2};
        g27y = '{0, 1, 2, 3, 4, 5};

        #12;
        check("reset_ready", ready, 1);
        check("reset_write", pixel_write, 0);
        check("reset_x", pixel_x, 0);
        check("reset_y", pixel_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_line(tab[i].x1, tab[i].y1, tab[i].x2, tab[i].y2, tab[i].mode, 0);
            check($sformatf("table%0d_count", i), got_q.size(), tab[i].cnt);
            if (i == 1 && got_q.size() == 6)
                for (int k = 0; k < 6; k++)
                    check($sformatf("line27_px%0d", k), got_q[k], pk(g27x[k], g27y[k]));
            if (i == 2 && got_q.size() == 6)
                for (int k = 0; k < 6; k++)
                    check($sformatf("line28_px%0d", k), got_q[k], pk(10 - k, 10 + k));
        end

        for (int r = 0; r < 20; r++) begin
            ax1 = $urandom_range(0, H-1); ax2 = $urandom_range(0, H-1);
            ay1 = $urandom_range(0, V-1); ay2 = $urandom_range(0, V-1);
            if (r < 5) begin ax2 = ax1 + $urandom_range(0, 3); if (ax2 >= H) ax2 = H-1; end
            run_line(ax1, ay1, ax2, ay2, 1, 0);
            check("rand_count", got_q.size(),
                  ((iabs(ax2-ax1) > iabs(ay2-ay1)) ? iabs(ax2-ax1) : iabs(ay2-ay1)) + 1);
        end

        run_line(0, 0, 50, 0, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready, 1);
        check("async_rst_write", pixel_write, 0);
        check("async_rst_x", pixel_x, 0);
        check("async_rst_y", pixel_y, 0);
        #1 rst_n = 1'b1;
        pixel_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pixel_write) writes++;
        end
        check("post_rst_writes", writes, 0);
        check("post_rst_ready", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
